// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program-memory loader: state encoding and size defaults.
package prog_mem_pkg;

    localparam int PM_ADDR_W = 4;
    localparam int PM_DATA_W = 8;
    localparam int PM_DEPTH  = 2 ** PM_ADDR_W;

    // Code 3 is never produced; the loader treats it exactly like CLEAR.
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } pm_state_e;

endpackage : prog_mem_pkg

// File: rtl/prog_mem_ram.sv
// DEPTH x DATA_W program memory: one synchronous write port, asynchronous read.
module prog_mem_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port; contents are never reset, the loader sweeps them to zero.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The CPU fetches combinationally from the current address.
    assign rdata = mem[raddr];

endmodule : prog_mem_ram

// File: rtl/prog_mem_loader.sv
// Program-memory loader: clears memory, streams a program in, then releases the CPU.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = PM_ADDR_W,
    parameter int DATA_W = PM_DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              ld_start,
    output logic              cpu_reset_n,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_data_w,
    input  logic              mem_we,
    output logic [DATA_W-1:0] mem_data_r,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    pm_state_e         state_reg, state_next;
    logic [ADDR_W-1:0] counter_reg, counter_next;
    logic              cpu_reset_n_reg;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // State, address counter and the registered CPU reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= CLEAR;
            counter_reg     <= '0;
            cpu_reset_n_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            counter_reg     <= counter_next;
            cpu_reset_n_reg <= (state_next == RUN);
        end
    end

    // Next-state logic and the single write-port mux (CLEAR > LOAD > CPU by state).
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        wr_en        = 1'b0;
        wr_addr      = counter_reg;
        wr_data      = '0;
        ld_ready     = 1'b0;
        case (state_reg)
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    wr_en        = 1'b1;
                    wr_data      = ld_data;
                    counter_next = counter_reg + 1'b1;
                    // Final byte either flagged or forced by a full memory; no wrap.
                    if (ld_last || (counter_reg == LAST_ADDR)) begin
                        state_next   = RUN;
                        counter_next = '0;
                    end
                end
            end
            RUN: begin
                if (mem_we) begin
                    wr_en   = 1'b1;
                    wr_addr = mem_address;
                    wr_data = mem_data_w;
                end
                // A simultaneous CPU write still lands; the sweep overwrites it later.
                if (ld_start) begin
                    state_next   = CLEAR;
                    counter_next = '0;
                end
            end
            default: begin
                // CLEAR, and the unused code 3: zero one word per cycle.
                wr_en        = 1'b1;
                wr_data      = '0;
                counter_next = counter_reg + 1'b1;
                if (counter_reg == LAST_ADDR) begin
                    state_next   = LOAD;
                    counter_next = '0;
                end
            end
        endcase
    end

    prog_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en && reset_n),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (mem_address),
        .rdata (mem_data_r)
    );

    assign cpu_reset_n = cpu_reset_n_reg;
    assign dbg_state   = state_reg;

endmodule : prog_mem_loader

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: directed scenarios plus random traffic.
module tb_prog_mem_loader;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic          clk;
    logic          reset_n;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          ld_start;
    logic          cpu_reset_n;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_w;
    logic          mem_we;
    logic [DW-1:0] mem_data_r;
    logic [1:0]    dbg_state;

    int check_count = 0;
    int error_count = 0;

    prog_mem_loader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .ld_start    (ld_start),
        .cpu_reset_n (cpu_reset_n),
        .mem_address (mem_address),
        .mem_data_w  (mem_data_w),
        .mem_we      (mem_we),
        .mem_data_r  (mem_data_r),
        .dbg_state   (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // The model tracks which phase the block is in, how many words the sweep
    // has zeroed, and how many program bytes have been taken.
    localparam int PH_CLEAR = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_RUN   = 2;

    logic [DW-1:0] model_mem [N];
    int  phase       = PH_CLEAR;
    int  swept       = 0;
    int  loaded      = 0;
    bit  mem_known   = 1'b0;
    bit  chk_en      = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            phase  = PH_CLEAR;
            swept  = 0;
            loaded = 0;
        end else if (phase == PH_CLEAR) begin
            model_mem[swept] = '0;
            swept = swept + 1;
            if (swept == N) begin
                phase     = PH_LOAD;
                loaded    = 0;
                mem_known = 1'b1;
            end
        end else if (phase == PH_LOAD) begin
            if (ld_valid) begin
                model_mem[loaded] = ld_data;
                loaded = loaded + 1;
                if (ld_last || loaded == N) phase = PH_RUN;
            end
        end else begin
            if (mem_we) model_mem[int'(mem_address)] = mem_data_w;
            if (ld_start) begin
                phase = PH_CLEAR;
                swept = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        check_count++;
        if (act != exp) begin
            error_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", int'(dbg_state), phase);
            check("ld_ready", int'(ld_ready), int'(phase == PH_LOAD));
            check("cpu_reset_n", int'(cpu_reset_n), int'(phase == PH_RUN));
            if (mem_known)
                check("mem_data_r", int'(mem_data_r), int'(model_mem[int'(mem_address)]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic read_check(input string name, input int addr, input int exp);
        mem_address = AW'(addr);
        #1;
        check(name, int'(mem_data_r), exp);
        tick();
    endtask

    logic [DW-1:0] prog4 [4];
    logic [DW-1:0] loaded_vals [N];

    initial begin
        int sent;
        prog4[0] = 8'h90; prog4[1] = 8'hA1; prog4[2] = 8'h20; prog4[3] = 8'h00;

        reset_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        ld_start = 1'b0; mem_address = '0; mem_data_w = '0; mem_we = 1'b0;
        ticks(2);
        chk_en = 1'b1;
        check("reset_state", int'(dbg_state), 0);
        check("reset_cpu_reset_n", int'(cpu_reset_n), 0);
        check("reset_ld_ready", int'(ld_ready), 0);
        reset_n = 1'b1;

        // Idle sweep: LOAD after exactly 16 cycles, memory all zero.
        ticks(15);
        check("sweep_not_done_15", int'(dbg_state), 0);
        tick();
        check("sweep_done_state", int'(dbg_state), 1);
        check("sweep_done_ready", int'(ld_ready), 1);
        for (int a = 0; a < N; a++) read_check("sweep_zero", a, 0);

        // Short program with ld_last on the fourth byte.
        for (int i = 0; i < 3; i++) begin
            send(prog4[i], 1'b0);
            check("short_cpu_held", int'(cpu_reset_n), 0);
        end
        send(prog4[3], 1'b1);
        check("short_cpu_release", int'(cpu_reset_n), 1);
        check("short_state_run", int'(dbg_state), 2);
        for (int a = 0; a < N; a++)
            read_check("short_contents", a, (a < 4) ? int'(prog4[a]) : 0);

        // CPU write in RUN.
        mem_we = 1'b1; mem_address = 4'hE; mem_data_w = 8'h07;
        tick();
        mem_we = 1'b0;
        check("run_write", int'(mem_data_r), 8'h07);

        // Reprogram request coincident with a CPU write.
        ld_start = 1'b1; mem_we = 1'b1; mem_address = 4'hE; mem_data_w = 8'h55;
        tick();
        ld_start = 1'b0; mem_we = 1'b0;
        check("restart_cpu_reset_n", int'(cpu_reset_n), 0);
        check("restart_state", int'(dbg_state), 0);
        check("restart_write_landed", int'(mem_data_r), 8'h55);
        ticks(16);
        check("restart_state_load", int'(dbg_state), 1);
        read_check("restart_e_cleared", 14, 0);

        // Full 16-byte stream with a gappy valid; RUN after the byte at address 15.
        sent = 0;
        for (int k = 0; k < 400 && sent < N; k++) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = ld_valid ? DW'(8'h10 + sent) : DW'($urandom);
            ld_last  = 1'b0;
            tick();
            if (ld_valid) sent++;
        end
        ld_valid = 1'b0;
        check("full_all_sent", sent, N);
        check("full_state_run", int'(dbg_state), 2);
        ld_valid = 1'b1; ld_data = 8'hEE;
        ticks(3);
        ld_valid = 1'b0;
        for (int a = 0; a < N; a++) read_check("full_contents", a, 8'h10 + a);

        // CPU writes during LOAD are ignored; ld_last on the final address.
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ticks(16);
        mem_we = 1'b1; mem_address = 4'hE; mem_data_w = 8'h07;
        for (int i = 0; i < N; i++) begin
            loaded_vals[i] = DW'($urandom);
            if (loaded_vals[i] == 8'h07) loaded_vals[i] = 8'h08;
            send(loaded_vals[i], i == N - 1);
        end
        mem_we = 1'b0;
        check("last_at_end_state", int'(dbg_state), 2);
        read_check("load_ignores_cpu", 14, int'(loaded_vals[14]));
        read_check("no_wrap_addr0", 0, int'(loaded_vals[0]));

        // Reset in the middle of a load.
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ticks(16);
        for (int i = 0; i < 5; i++) send(DW'(8'hC0 + i), 1'b0);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("midload_reset_state", int'(dbg_state), 0);
        ticks(16);
        check("midload_reload_state", int'(dbg_state), 1);
        send(8'hAB, 1'b1);
        read_check("midload_first_at_0", 0, 8'hAB);
        read_check("midload_addr1_zero", 1, 0);

        // Random traffic checked against the model every cycle.
        for (int k = 0; k < 1500; k++) begin
            reset_n     = ($urandom_range(0, 299) != 0);
            ld_valid    = 1'($urandom_range(0, 1));
            ld_data     = DW'($urandom);
            ld_last     = ($urandom_range(0, 7) == 0);
            ld_start    = ($urandom_range(0, 39) == 0);
            mem_we      = 1'($urandom_range(0, 1));
            mem_address = AW'($urandom);
            mem_data_w  = DW'($urandom);
            tick();
        end
        reset_n = 1'b1; ld_valid = 1'b0; ld_start = 1'b0; mem_we = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule : tb_prog_mem_loader
